fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer sitting directly downstream of the program counter register and upstream of decode. It reads the current PC and issues a req/ack read to instruction memory. It captures the returned word into an instruction register for decode. It drives the PC's load/increment/new-value controls for sequential advance (+4) and branch redirect.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
DATA_W, 32, instruction word width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
pc  input  ADDR_W  current PC value from PC register
pc_ld  output  1  PC load enable (combinational)
pc_inc  output  1  with pc_ld: 1 = PC+4, 0 = load pc_new (combinational)
pc_new  output  ADDR_W  redirect target to PC (combinational)
imem_req  output  1  memory read request, level
imem_addr  output  ADDR_W  registered request address
imem_ack  input  1  read data valid / request complete, single-cycle pulse
imem_rdata  input  DATA_W  read data, valid with imem_ack
br_take  input  1  redirect request from execute
br_target  input  ADDR_W  redirect address
stall  input  1  inhibit starting a new fetch
ir  output  DATA_W  fetched instruction
ir_pc  output  ADDR_W  address ir was fetched from
ir_valid  output  1  ir holds an unconsumed instruction
ir_ready  input  1  decode accepts ir this cycle
addr_err  output  1  sticky misaligned-PC flag

Behaviour:
- Reset behaviour: reset is asynchronous, active-high; clock clk. On reset: state=IDLE; imem_req, imem_addr, ir, ir_pc, ir_valid, addr_err all 0. Combinational outputs are 0 while reset is high.
- States: IDLE, REQ, VALID, DRAIN, ERR.
- IDLE, stall=0:
  - If pc[1:0]!=0: go to ERR and set addr_err.
  - Else: req_addr<=pc, go to REQ.
- IDLE, stall=1: hold.
- REQ: imem_req=1, imem_addr=req_addr, held stable until ack.
- REQ with imem_ack and no br_take:
  - ir<=imem_rdata, ir_pc<=req_addr, ir_valid<=1.
  - Same cycle: pc_ld=1, pc_inc=1.
  - Go to VALID.
- Fetch latency: minimum 2 cycles from IDLE to ir_valid (IDLE, REQ with ack same cycle). Memory wait states add cycles in REQ.
- VALID: ir_valid=1; ir and ir_pc held.
  - ir_ready=1, stall=0: ir_valid<=0; if pc misaligned go to ERR, else req_addr<=pc and go to REQ. This gives back-to-back fetch.
  - ir_ready=1, stall=1: ir_valid<=0, go to IDLE.
  - ir_ready=0: hold.
- Redirect (br_take=1) has priority over all non-reset events, in every state:
  - Same cycle: pc_ld=1, pc_inc=0, pc_new=br_target; ir_valid<=0.
  - From REQ without ack, or from DRAIN without ack: go to DRAIN.
  - From REQ or DRAIN with ack: data discarded, go to IDLE.
  - From IDLE, VALID or ERR: go to IDLE and clear addr_err.
- DRAIN: imem_req=1 at the old req_addr until imem_ack. Data is discarded, then go to IDLE. The redirected PC is fetched from IDLE on the next cycle.
- ERR: no requests issued; addr_err=1 until br_take or reset.
- imem_ack outside REQ/DRAIN is ignored.
- pc_ld=0, pc_inc=0 and pc_new=0 whenever no advance or redirect occurs. pc_inc is never 1 with pc_ld=0.
- PC increment wraps modulo 2^ADDR_W, so 0xFFFFFFFC advances to 0x00000000. The wrap is performed by the PC register; fetch_ctrl only signals it.
- stall never aborts an in-flight request.
- Reset asserted mid-request drops imem_req immediately.

Test Plan:
- Reset, then ack on every REQ cycle with rdata=0xA0000000+addr, ir_ready=1 → ir_pc sequence 0x0,0x4,0x8; ir 0xA0000000,0xA0000004; one pc_ld+pc_inc pulse per fetch.
- Memory ack delayed 3 cycles at addr 0x10 → imem_req held 4 cycles, imem_addr stable 0x10, ir_valid rises the cycle after ack.
- br_take with br_target=0x200 during REQ at 0x8, ack 2 cycles later with 0xDEAD → ack data discarded (ir not updated, ir_valid stays 0); pc_ld=1/pc_inc=0/pc_new=0x200 pulse; next fetch address 0x200.
- ir_ready=0 for 5 cycles in VALID → ir, ir_pc and ir_valid held, no imem_req; ir_ready=1 → next REQ at ir_pc+4.
- br_target=0x102 → ERR; addr_err=1, no imem_req. br_take with target 0x100 → addr_err=0, fetch at 0x100.
- Reset asserted while imem_req=1 → imem_req, ir_valid and addr_err 0 asynchronously; fetch restarts at 0x0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues req/ack reads at the PC, captures the
// returned word for decode, and drives PC advance/redirect controls.
module fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] pc_new,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              stall,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              addr_err
);

  typedef enum logic [2:0] {IDLE, REQ, VALID, DRAIN, ERR} state_t;

  state_t state, state_nx;
  logic   start_req, cap_ir, clr_valid, set_err, clr_err;
  logic   misalign;

  assign misalign = |pc[1:0];
  // Request is a pure function of state, so async reset drops it at once.
  assign imem_req = (state == REQ) || (state == DRAIN);

  always_comb begin
    state_nx  = state;
    start_req = 1'b0;
    cap_ir    = 1'b0;
    clr_valid = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    pc_ld     = 1'b0;
    pc_inc    = 1'b0;
    pc_new    = '0;
    if (!reset) begin
      if (br_take) begin
        pc_ld     = 1'b1;
        pc_new    = br_target;
        clr_valid = 1'b1;
        if (state == REQ || state == DRAIN) begin
          // An outstanding read must complete before a new one can start.
          state_nx = imem_ack ? IDLE : DRAIN;
        end else begin
          state_nx = IDLE;
          clr_err  = 1'b1;
        end
      end else begin
        case (state)
          IDLE: if (!stall) begin
            if (misalign) begin
              state_nx = ERR;
              set_err  = 1'b1;
            end else begin
              state_nx  = REQ;
              start_req = 1'b1;
            end
          end
          REQ: if (imem_ack) begin
            cap_ir   = 1'b1;
            pc_ld    = 1'b1;
            pc_inc   = 1'b1;
            state_nx = VALID;
          end
          VALID: if (ir_ready) begin
            clr_valid = 1'b1;
            if (stall) begin
              state_nx = IDLE;
            end else if (misalign) begin
              state_nx = ERR;
              set_err  = 1'b1;
            end else begin
              state_nx  = REQ;
              start_req = 1'b1;
            end
          end
          DRAIN: if (imem_ack) state_nx = IDLE;
          ERR:   state_nx = ERR;
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      imem_addr <= '0;
      ir        <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_req) imem_addr <= pc;
      if (cap_ir) begin
        ir       <= imem_rdata;
        ir_pc    <= imem_addr;
        ir_valid <= 1'b1;
      end else if (clr_valid) begin
        ir_valid <= 1'b0;
      end
      if (set_err)      addr_err <= 1'b1;
      else if (clr_err) addr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC register model and a wait-state
// instruction memory responder.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc;
  logic        pc_ld, pc_inc;
  logic [31:0] pc_new;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        br_take = 1'b0;
  logic [31:0] br_target = '0;
  logic        stall = 1'b1;
  logic [31:0] ir, ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        addr_err;

  int          vectors = 0;
  int          miscompares = 0;
  int          mem_wait = 0;
  int          wcnt;
  logic        use_ovr = 1'b0;
  logic [31:0] ovr_data = '0;
  logic [31:0] pc_rst = '0;

  fetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .pc_new(pc_new), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .br_take(br_take),
    .br_target(br_target), .stall(stall), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Program counter register the controller drives.
  always @(posedge clk or posedge reset) begin
    if (reset)      pc <= pc_rst;
    else if (pc_ld) pc <= pc_inc ? pc + 32'd4 : pc_new;
  end

  // Memory acks after mem_wait extra cycles of a held request.
  always @(posedge clk or posedge reset) begin
    if (reset)                     wcnt <= 0;
    else if (!imem_req || imem_ack) wcnt <= 0;
    else                           wcnt <= wcnt + 1;
  end
  assign imem_ack   = imem_req && (wcnt == mem_wait);
  assign imem_rdata = use_ovr ? ovr_data : 32'hA000_0000 + imem_addr;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [31:0] start);
    stall = 1'b1; br_take = 1'b0; ir_ready = 1'b0; mem_wait = 0;
    use_ovr = 1'b0; pc_rst = start;
    #2 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    stall = 1'b1;
    reset = 1'b1; #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    vectors++; if ({ir_valid, addr_err} !== 2'b00) begin miscompares++; $display("FAIL rst_flags: got %b want 00", {ir_valid, addr_err}); end
    vectors++; if ({ir, ir_pc} !== 64'h0) begin miscompares++; $display("FAIL rst_ir: got %h want 0", {ir, ir_pc}); end
    br_take = 1'b1; br_target = 32'h40; #1;
    vectors++; if ({pc_ld, pc_inc, pc_new} !== 34'h0) begin miscompares++; $display("FAIL rst_comb: got %h want 0", {pc_ld, pc_inc, pc_new}); end
    br_take = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_seq();
    do_reset(32'h0);
    ir_ready = 1'b1; stall = 1'b0;
    vectors++; if (pc_ld !== 1'b0) begin miscompares++; $display("FAIL seq_idle_ld: got %b want 0", pc_ld); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*i)) begin miscompares++; $display("FAIL seq_req%0d: got %b/%h want 1/%h", i, imem_req, imem_addr, 4*i); end
      vectors++; if ({pc_ld, pc_inc} !== 2'b11) begin miscompares++; $display("FAIL seq_adv%0d: got %b want 11", i, {pc_ld, pc_inc}); end
      tick();
      vectors++; if (ir_valid !== 1'b1 || ir_pc !== 32'(4*i)) begin miscompares++; $display("FAIL seq_irpc%0d: got %b/%h want 1/%h", i, ir_valid, ir_pc, 4*i); end
      vectors++; if (ir !== 32'hA000_0000 + 32'(4*i)) begin miscompares++; $display("FAIL seq_ir%0d: got %h want %h", i, ir, 32'hA000_0000 + 32'(4*i)); end
      vectors++; if ({pc_ld, pc_inc, imem_req} !== 3'b000) begin miscompares++; $display("FAIL seq_valid%0d: got %b want 000", i, {pc_ld, pc_inc, imem_req}); end
    end
  endtask

  task automatic test_wait();
    do_reset(32'h10);
    mem_wait = 3; stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin miscompares++; $display("FAIL wait_req%0d: got %b/%h want 1/10", i, imem_req, imem_addr); end
      vectors++; if (ir_valid !== 1'b0 || pc_ld !== (i == 3)) begin miscompares++; $display("FAIL wait_ld%0d: got %b/%b want 0/%b", i, ir_valid, pc_ld, i == 3); end
    end
    stall = 1'b1;
    tick();
    vectors++; if (ir_valid !== 1'b1 || ir_pc !== 32'h10 || ir !== 32'hA000_0010) begin miscompares++; $display("FAIL wait_ir: got %b/%h/%h want 1/10/a0000010", ir_valid, ir_pc, ir); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL wait_noreq: got %b want 0", imem_req); end
  endtask

  task automatic test_redirect();
    do_reset(32'h8);
    mem_wait = 2; use_ovr = 1'b1; ovr_data = 32'h0000_DEAD; stall = 1'b0; ir_ready = 1'b1;
    tick();
    br_take = 1'b1; br_target = 32'h200; #1;
    vectors++; if ({pc_ld, pc_inc} !== 2'b10 || pc_new !== 32'h200) begin miscompares++; $display("FAIL br_pulse: got %b/%h want 10/200", {pc_ld, pc_inc}, pc_new); end
    tick();
    br_take = 1'b0; #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin miscompares++; $display("FAIL br_drain: got %b/%h want 1/8", imem_req, imem_addr); end
    vectors++; if ({pc_ld, pc_new} !== 33'h0) begin miscompares++; $display("FAIL br_quiet: got %h want 0", {pc_ld, pc_new}); end
    tick();
    vectors++; if (imem_ack !== 1'b1 || pc_ld !== 1'b0) begin miscompares++; $display("FAIL br_ack: got %b/%b want 1/0", imem_ack, pc_ld); end
    tick();
    vectors++; if (ir_valid !== 1'b0 || ir !== 32'h0 || imem_req !== 1'b0) begin miscompares++; $display("FAIL br_discard: got %b/%h/%b want 0/0/0", ir_valid, ir, imem_req); end
    tick();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL br_next: got %b/%h want 1/200", imem_req, imem_addr); end
    use_ovr = 1'b0;
  endtask

  task automatic test_hold();
    do_reset(32'h0);
    stall = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0 || ir !== 32'hA000_0000 || imem_req !== 1'b0) begin miscompares++; $display("FAIL hold%0d: got %b/%h/%h/%b want 1/0/a0000000/0", i, ir_valid, ir_pc, ir, imem_req); end
    end
    ir_ready = 1'b1;
    tick();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || ir_valid !== 1'b0) begin miscompares++; $display("FAIL hold_next: got %b/%h/%b want 1/4/0", imem_req, imem_addr, ir_valid); end
  endtask

  task automatic test_err();
    do_reset(32'h0);
    br_take = 1'b1; br_target = 32'h102; #1;
    vectors++; if ({pc_ld, pc_inc} !== 2'b10 || pc_new !== 32'h102) begin miscompares++; $display("FAIL err_br: got %b/%h want 10/102", {pc_ld, pc_inc}, pc_new); end
    tick();
    br_take = 1'b0; stall = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++; if (addr_err !== 1'b1 || imem_req !== 1'b0) begin miscompares++; $display("FAIL err_hold%0d: got %b/%b want 1/0", i, addr_err, imem_req); end
      tick();
    end
    br_take = 1'b1; br_target = 32'h100; #1;
    vectors++; if (pc_ld !== 1'b1 || pc_new !== 32'h100) begin miscompares++; $display("FAIL err_redir: got %b/%h want 1/100", pc_ld, pc_new); end
    tick();
    br_take = 1'b0; #1;
    vectors++; if (addr_err !== 1'b0) begin miscompares++; $display("FAIL err_clr: got %b want 0", addr_err); end
    tick();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL err_fetch: got %b/%h want 1/100", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset(32'h0);
    mem_wait = 5; stall = 1'b0;
    tick(); tick();
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got %b want 1", imem_req); end
    #2 reset = 1'b1; #1;
    vectors++; if ({imem_req, ir_valid, addr_err} !== 3'b000 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_async: got %b/%h want 000/0", {imem_req, ir_valid, addr_err}, imem_addr); end
    @(posedge clk); #1 reset = 1'b0; mem_wait = 0;
    tick();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_restart: got %b/%h want 1/0", imem_req, imem_addr); end
    tick();
    vectors++; if (ir_valid !== 1'b1 || ir !== 32'hA000_0000) begin miscompares++; $display("FAIL mid_ir: got %b/%h want 1/a0000000", ir_valid, ir); end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_wait();
    test_redirect();
    test_hold();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
